// File: rtl/i2s_tx_gen_pkg.sv
// Shared I2S definitions for the transmit and receive paths.
// Word-select polarity, default widths and frame-size helpers live here so
// both directions agree on framing without duplicating constants.
package i2s_tx_gen_pkg;

    // Word-select polarity: left slot first, right slot second.
    localparam logic I2S_WS_LEFT  = 1'b0;
    localparam logic I2S_WS_RIGHT = 1'b1;

    // Default geometry shared by transmit and receive.
    localparam int I2S_DEF_DATA_BITS = 16;
    localparam int I2S_DEF_SLOT_BITS = 32;
    localparam int I2S_DEF_BCK_DIV   = 8;

    // Number of BCK periods in one stereo frame.
    function automatic int frame_bits(input int slot_bits);
        return 2 * slot_bits;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: free-running AMCLK_i divider producing a 50% duty
// registered BCK and a one-cycle strobe on the cycle that drives BCK low.
module i2s_bck_gen
    import i2s_tx_gen_pkg::*;
#(
    parameter int BCK_DIV = I2S_DEF_BCK_DIV
) (
    input  logic AMCLK_i,
    input  logic reset_n,
    output logic bck,
    output logic fall_evt
);

    localparam int DW = ctr_width(BCK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
    localparam logic [DW-1:0] DIV_RISE = DW'(BCK_DIV / 2 - 1);

    logic [DW-1:0] div_ctr;

    // Free-running divider, wrapping after BCK_DIV cycles.
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            div_ctr <= '0;
        end else if (div_ctr == DIV_LAST) begin
            div_ctr <= '0;
        end else begin
            div_ctr <= div_ctr + DW'(1);
        end
    end

    // BCK goes high halfway through the divider period and low at its end.
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            bck <= 1'b0;
        end else if (div_ctr == DIV_RISE) begin
            bck <= 1'b1;
        end else if (div_ctr == DIV_LAST) begin
            bck <= 1'b0;
        end
    end

    // The fall strobe is combinational so the serializer updates WS/DATA on
    // the very edge that drives BCK low.
    assign fall_evt = (div_ctr == DIV_LAST);

endmodule

// File: rtl/i2s_tx_gen.sv
// I2S master transmitter. Parallel stereo samples are captured into a
// single-entry holding buffer and loaded once per frame into the active
// shift source. WS and DATA change on the BCK falling edge; the receiver
// samples on the rising edge. Missing samples repeat the previous frame.
module i2s_tx_gen
    import i2s_tx_gen_pkg::*;
#(
    parameter int I2S_DATA_BITS = I2S_DEF_DATA_BITS,
    parameter int SLOT_BITS     = I2S_DEF_SLOT_BITS,
    parameter int BCK_DIV       = I2S_DEF_BCK_DIV
) (
    input  logic                     AMCLK_i,
    input  logic                     reset_n,
    input  logic [I2S_DATA_BITS-1:0] APDATA_LEFT_i,
    input  logic [I2S_DATA_BITS-1:0] APDATA_RIGHT_i,
    input  logic                     APDATA_VALID_i,
    output logic                     SAMPLE_REQ_o,
    output logic                     UNDERRUN_o,
    output logic                     OVERRUN_o,
    output logic                     I2S_BCK,
    output logic                     I2S_WS,
    output logic                     I2S_DATA
);

    localparam int FRAME_BITS = frame_bits(SLOT_BITS);
    localparam int CW         = ctr_width(FRAME_BITS);
    localparam int DIW        = ctr_width(I2S_DATA_BITS);

    localparam logic [CW-1:0] K_LAST  = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] K_RIGHT = CW'(SLOT_BITS);

    // Bit position within the frame; reset parks it on the last position so
    // the first fall event enters position 0 and performs the first load.
    logic [CW-1:0] bit_ctr;
    logic [CW-1:0] next_k;
    logic          fall_evt;
    logic          load_evt;
    logic          next_data;
    int            k_int;

    // Holding buffer, active (being shifted) pair and last loaded pair.
    logic [I2S_DATA_BITS-1:0] hold_l, hold_r;
    logic [I2S_DATA_BITS-1:0] act_l, act_r;
    logic [I2S_DATA_BITS-1:0] last_l, last_r;
    logic                     pending;

    i2s_bck_gen #(
        .BCK_DIV (BCK_DIV)
    ) u_bck (
        .AMCLK_i  (AMCLK_i),
        .reset_n  (reset_n),
        .bck      (I2S_BCK),
        .fall_evt (fall_evt)
    );

    assign next_k   = (bit_ctr == K_LAST) ? '0 : bit_ctr + CW'(1);
    assign load_evt = fall_evt && (next_k == '0);

    // Data bit for the position being entered. Bits are delayed one BCK
    // after each WS edge; position 0 carries the previous right LSB only
    // when the data fills the whole slot. It reads the pre-load right word.
    always_comb begin
        k_int     = int'(next_k);
        next_data = 1'b0;
        if ((k_int >= 1) && (k_int <= I2S_DATA_BITS)) begin
            next_data = act_l[DIW'(I2S_DATA_BITS - k_int)];
        end else if ((k_int >= SLOT_BITS + 1) &&
                     (k_int <= SLOT_BITS + I2S_DATA_BITS)) begin
            next_data = act_r[DIW'(SLOT_BITS + I2S_DATA_BITS - k_int)];
        end else if ((I2S_DATA_BITS == SLOT_BITS) && (k_int == 0)) begin
            next_data = act_r[0];
        end
    end

    // Serializer: advance the frame position, WS and DATA on each fall event.
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            bit_ctr  <= K_LAST;
            I2S_WS   <= I2S_WS_RIGHT;
            I2S_DATA <= 1'b0;
        end else if (fall_evt) begin
            bit_ctr  <= next_k;
            I2S_WS   <= (next_k < K_RIGHT) ? I2S_WS_LEFT : I2S_WS_RIGHT;
            I2S_DATA <= next_data;
        end
    end

    // Frame load from the holding buffer, or repeat of the last pair when
    // nothing new arrived. Pulse outputs default low every cycle.
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            act_l        <= '0;
            act_r        <= '0;
            last_l       <= '0;
            last_r       <= '0;
            SAMPLE_REQ_o <= 1'b0;
            UNDERRUN_o   <= 1'b0;
        end else begin
            SAMPLE_REQ_o <= 1'b0;
            UNDERRUN_o   <= 1'b0;
            if (load_evt) begin
                SAMPLE_REQ_o <= 1'b1;
                if (pending) begin
                    act_l  <= hold_l;
                    act_r  <= hold_r;
                    last_l <= hold_l;
                    last_r <= hold_r;
                end else begin
                    act_l      <= last_l;
                    act_r      <= last_r;
                    UNDERRUN_o <= 1'b1;
                end
            end
        end
    end

    // Input capture. A load drains pending, but a valid on the same edge
    // refills it; the load itself still sees the pre-edge holding buffer.
    // Overwriting an undrained sample is an overrun, except on a load edge
    // where the old sample is being consumed at that moment.
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            hold_l    <= '0;
            hold_r    <= '0;
            pending   <= 1'b0;
            OVERRUN_o <= 1'b0;
        end else begin
            OVERRUN_o <= 1'b0;
            if (load_evt) begin
                pending <= 1'b0;
            end
            if (APDATA_VALID_i) begin
                hold_l  <= APDATA_LEFT_i;
                hold_r  <= APDATA_RIGHT_i;
                pending <= 1'b1;
                if (pending && !load_evt) begin
                    OVERRUN_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_gen.sv
// Directed bench for i2s_tx_gen: a 16/32/8 instance for framing, buffering
// and reset behaviour, and a 16/16/4 instance for the full-slot delay case.
module tb_i2s_tx_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] l_in, r_in;
    logic        v_in;
    logic        req, ur, ov, bck, ws, data;

    logic [15:0] l16, r16;
    logic        v16;
    logic        req16, ur16, ov16, bck16, ws16, data16;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_load_cyc;
    bit data_hi;
    int ov_total, ur_total;
    int rd_idx;

    // Decoded slots from the rising-edge sampler
    bit          sq_ws[$];
    logic [15:0] sq_word[$];
    bit          sq_zero[$];
    bit          s_ws;
    int          s_pos;
    logic [15:0] s_word;
    bit          s_zero;

    i2s_tx_gen #(.I2S_DATA_BITS(16), .SLOT_BITS(32), .BCK_DIV(8)) dut (
        .AMCLK_i(clk), .reset_n(reset_n),
        .APDATA_LEFT_i(l_in), .APDATA_RIGHT_i(r_in), .APDATA_VALID_i(v_in),
        .SAMPLE_REQ_o(req), .UNDERRUN_o(ur), .OVERRUN_o(ov),
        .I2S_BCK(bck), .I2S_WS(ws), .I2S_DATA(data)
    );

    i2s_tx_gen #(.I2S_DATA_BITS(16), .SLOT_BITS(16), .BCK_DIV(4)) dut16 (
        .AMCLK_i(clk), .reset_n(reset_n),
        .APDATA_LEFT_i(l16), .APDATA_RIGHT_i(r16), .APDATA_VALID_i(v16),
        .SAMPLE_REQ_o(req16), .UNDERRUN_o(ur16), .OVERRUN_o(ov16),
        .I2S_BCK(bck16), .I2S_WS(ws16), .I2S_DATA(data16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled on the falling edge
    initial begin
        ov_total = 0;
        ur_total = 0;
        forever begin
            @(negedge clk);
            if (ov === 1'b1) ov_total++;
            if (ur === 1'b1) ur_total++;
        end
    end

    // Receiver model: sample on BCK rise, slot restarts at each WS change,
    // bits 1..16 of a slot are the word MSB first, bits 17.. must be zero.
    initial begin
        s_ws   = 1'b1;
        s_pos  = 0;
        s_word = '0;
        s_zero = 1'b1;
        forever begin
            @(posedge bck);
            if (ws !== s_ws) begin
                sq_ws.push_back(s_ws);
                sq_word.push_back(s_word);
                sq_zero.push_back(s_zero);
                s_ws   = ws;
                s_pos  = 0;
                s_word = '0;
                s_zero = 1'b1;
            end else begin
                s_pos++;
                if (s_pos <= 16) s_word = {s_word[14:0], data};
                else if (data !== 1'b0) s_zero = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the next frame load; a missing load is a failed comparison.
    task automatic wait_load(input string name);
        bit hit;
        hit     = 1'b0;
        data_hi = 1'b0;
        for (int i = 0; i < 1100 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (data === 1'b1) data_hi = 1'b1;
            if (req === 1'b1) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL %s_load: no SAMPLE_REQ_o within 1100 cycles, required one", name);
        end
        last_load_cyc = cyc;
    endtask

    task automatic get_frame(output int n, output logic [15:0] l, output logic [15:0] r,
                             output bit ok);
        n  = sq_word.size() - rd_idx;
        l  = '0;
        r  = '0;
        ok = 1'b0;
        if (n == 2) begin
            l  = sq_word[rd_idx];
            r  = sq_word[rd_idx+1];
            ok = (sq_ws[rd_idx] == 1'b0) && (sq_ws[rd_idx+1] == 1'b1) &&
                 sq_zero[rd_idx] && sq_zero[rd_idx+1];
        end
        rd_idx = sq_word.size();
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        l_in = l;
        r_in = r;
        v_in = 1'b1;
        @(negedge clk);
        v_in = 1'b0;
    endtask

    task automatic test_reset;
        logic exp_bck, exp_ws, exp_p;
        reset_n = 1'b0;
        tick(5);
        n_cmp++;
        if ({bck, ws, data, req, ur, ov} !== 6'b010000) begin
            n_err++;
            $display("FAIL reset_values: got bck/ws/data/req/ur/ov=%b required 010000",
                     {bck, ws, data, req, ur, ov});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            exp_bck = (c >= 4 && c <= 7);
            exp_ws  = (c < 8);
            exp_p   = (c == 8);
            n_cmp++;
            if (bck !== exp_bck) begin
                n_err++;
                $display("FAIL reset_bck c%0d: got %b required %b", c, bck, exp_bck);
            end
            n_cmp++;
            if (ws !== exp_ws) begin
                n_err++;
                $display("FAIL reset_ws c%0d: got %b required %b", c, ws, exp_ws);
            end
            n_cmp++;
            if ({req, ur} !== {exp_p, exp_p}) begin
                n_err++;
                $display("FAIL reset_req_ur c%0d: got %b%b required %b%b", c, req, ur, exp_p, exp_p);
            end
            n_cmp++;
            if (data !== 1'b0) begin
                n_err++;
                $display("FAIL reset_data c%0d: got %b required 0", c, data);
            end
        end
        wait_load("first_frame");
        n_cmp++;
        if (data_hi !== 1'b0) begin
            n_err++;
            $display("FAIL first_frame_zero: got DATA=1 somewhere, required all 0");
        end
    endtask

    task automatic test_pattern;
        int n;
        logic [15:0] l, r;
        bit ok;
        send(16'h8001, 16'h7FFE);
        wait_load("pattern_load3");
        n_cmp++;
        if (ur !== 1'b0) begin
            n_err++;
            $display("FAIL pattern_no_underrun: got %b required 0", ur);
        end
        tick(6);
        rd_idx = sq_word.size();
        wait_load("pattern_load4");
        n_cmp++;
        if (ur !== 1'b1) begin
            n_err++;
            $display("FAIL pattern_underrun: got %b required 1", ur);
        end
        tick(6);
        get_frame(n, l, r, ok);
        n_cmp++;
        if (n !== 2 || l !== 16'h8001 || r !== 16'h7FFE || ok !== 1'b1) begin
            n_err++;
            $display("FAIL pattern_frame: got n=%0d L=%h R=%h ok=%b required 2 8001 7ffe 1", n, l, r, ok);
        end
    endtask

    task automatic test_underrun;
        int n, ur0;
        logic [15:0] l, r;
        bit ok;
        ur0 = ur_total;
        wait_load("underrun_load5");
        tick(6);
        n_cmp++;
        if (ur_total - ur0 !== 1) begin
            n_err++;
            $display("FAIL underrun_count: got %0d required 1", ur_total - ur0);
        end
        get_frame(n, l, r, ok);
        n_cmp++;
        if (n !== 2 || l !== 16'h8001 || r !== 16'h7FFE || ok !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_repeat: got n=%0d L=%h R=%h ok=%b required 2 8001 7ffe 1", n, l, r, ok);
        end
    endtask

    task automatic test_overrun;
        int n, ov0;
        logic [15:0] l, r;
        bit ok;
        ov0 = ov_total;
        send(16'h1111, 16'h2222);
        tick(20);
        send(16'h3333, 16'h4444);
        wait_load("overrun_load6");
        n_cmp++;
        if (ur !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_load_ur: got %b required 0", ur);
        end
        tick(6);
        n_cmp++;
        if (ov_total - ov0 !== 1) begin
            n_err++;
            $display("FAIL overrun_count: got %0d required 1", ov_total - ov0);
        end
        rd_idx = sq_word.size();
        wait_load("overrun_load7");
        tick(6);
        get_frame(n, l, r, ok);
        n_cmp++;
        if (n !== 2 || l !== 16'h3333 || r !== 16'h4444 || ok !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_frame: got n=%0d L=%h R=%h ok=%b required 2 3333 4444 1", n, l, r, ok);
        end
    endtask

    task automatic test_coincident;
        int n, ov0, target;
        logic [15:0] l, r;
        bit ok;
        target = last_load_cyc + 511;
        send(16'h5A5A, 16'hA5A5);
        ov0 = ov_total;
        for (int i = 0; i < 600 && cyc != target; i++) tick(1);
        @(negedge clk);
        l_in = 16'hC3C3;
        r_in = 16'h3C3C;
        v_in = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({req, ur} !== 2'b10) begin
            n_err++;
            $display("FAIL coincident_load: got req/ur=%b%b required 10", req, ur);
        end
        @(negedge clk);
        v_in = 1'b0;
        tick(6);
        rd_idx = sq_word.size();
        wait_load("coincident_load9");
        n_cmp++;
        if (ur !== 1'b0) begin
            n_err++;
            $display("FAIL coincident_pending: got underrun %b required 0", ur);
        end
        tick(6);
        get_frame(n, l, r, ok);
        n_cmp++;
        if (n !== 2 || l !== 16'h5A5A || r !== 16'hA5A5 || ok !== 1'b1) begin
            n_err++;
            $display("FAIL coincident_frame_d: got n=%0d L=%h R=%h ok=%b required 2 5a5a a5a5 1", n, l, r, ok);
        end
        wait_load("coincident_load10");
        tick(6);
        get_frame(n, l, r, ok);
        n_cmp++;
        if (n !== 2 || l !== 16'hC3C3 || r !== 16'h3C3C || ok !== 1'b1) begin
            n_err++;
            $display("FAIL coincident_frame_c: got n=%0d L=%h R=%h ok=%b required 2 c3c3 3c3c 1", n, l, r, ok);
        end
        n_cmp++;
        if (ov_total - ov0 !== 0) begin
            n_err++;
            $display("FAIL coincident_no_overrun: got %0d required 0", ov_total - ov0);
        end
    endtask

    task automatic test_mid_reset;
        int n, target;
        logic [15:0] l, r;
        bit ok, exp_bck;
        wait_load("midreset_load11");
        target = last_load_cyc + 325;
        send(16'h1234, 16'h5678);
        for (int i = 0; i < 600 && cyc != target; i++) tick(1);
        n_cmp++;
        if ({bck, ws} !== 2'b11) begin
            n_err++;
            $display("FAIL midreset_pre: got bck/ws=%b%b required 11", bck, ws);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bck, ws, data, req} !== 4'b0100) begin
            n_err++;
            $display("FAIL midreset_async: got bck/ws/data/req=%b required 0100", {bck, ws, data, req});
        end
        tick(3);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            exp_bck = (c >= 4 && c <= 7);
            n_cmp++;
            if (bck !== exp_bck) begin
                n_err++;
                $display("FAIL midreset_bck c%0d: got %b required %b", c, bck, exp_bck);
            end
        end
        n_cmp++;
        if ({req, ur, ws} !== 3'b110) begin
            n_err++;
            $display("FAIL midreset_first_load: got req/ur/ws=%b required 110", {req, ur, ws});
        end
        tick(6);
        rd_idx = sq_word.size();
        wait_load("midreset_load2");
        n_cmp++;
        if (ur !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_underrun2: got %b required 1", ur);
        end
        tick(6);
        get_frame(n, l, r, ok);
        n_cmp++;
        if (n !== 2 || l !== 16'h0000 || r !== 16'h0000 || ok !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_zero_frame: got n=%0d L=%h R=%h ok=%b required 2 0000 0000 1", n, l, r, ok);
        end
    endtask

    task automatic test_slot16;
        bit hit;
        logic prev;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick(1);
            if (req16 === 1'b1) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL slot16_load_a: no SAMPLE_REQ_o within 300 cycles, required one");
        end
        @(negedge clk);
        l16 = 16'h8000;
        r16 = 16'h0001;
        v16 = 1'b1;
        @(negedge clk);
        v16 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick(1);
            if (req16 === 1'b1) hit = 1'b1;
        end
        n_cmp++;
        if (!hit || ur16 !== 1'b0 || data16 !== 1'b0) begin
            n_err++;
            $display("FAIL slot16_load_b: got hit/ur/data=%b%b%b required 100", hit, ur16, data16);
        end
        tick(4);
        n_cmp++;
        if (data16 !== 1'b1) begin
            n_err++;
            $display("FAIL slot16_left_msb: got %b required 1", data16);
        end
        hit  = 1'b0;
        prev = 1'bx;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick(1);
            if (req16 === 1'b1) hit = 1'b1;
            else prev = data16;
        end
        n_cmp++;
        if (!hit || prev !== 1'b0 || data16 !== 1'b1 || ws16 !== 1'b0 || ur16 !== 1'b1) begin
            n_err++;
            $display("FAIL slot16_lsb_k0: got hit/prev/data/ws/ur=%b%b%b%b%b required 10101",
                     hit, prev, data16, ws16, ur16);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        l_in    = '0;
        r_in    = '0;
        v_in    = 1'b0;
        l16     = '0;
        r16     = '0;
        v16     = 1'b0;
        rd_idx  = 0;
        test_reset();
        test_pattern();
        test_underrun();
        test_overrun();
        test_coincident();
        test_mid_reset();
        test_slot16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx_gen.md
Name: i2s_tx_gen

Overview:
- I2S master transmitter. Accepts parallel stereo samples in the AMCLK_i domain and generates I2S_BCK, I2S_WS and I2S_DATA, all registered from AMCLK_i.
- Feeds external DACs/HDMI audio paths, and serves as the stimulus source for the I2S receive path in loopback.
- Uses a single-entry holding buffer with sample-request, underrun and overrun signalling.

Parameters:
- I2S_DATA_BITS, 16, valid bits per channel, MSB first, two's complement.
- SLOT_BITS, 32, BCK periods per channel slot; must be >= I2S_DATA_BITS.
- BCK_DIV, 8, AMCLK_i cycles per BCK period; power of 2, >= 2.

Ports:
- AMCLK_i  in  1  audio master clock; sole clock.
- reset_n  in  1  reset, asynchronous and active-low.
- APDATA_LEFT_i  in  I2S_DATA_BITS  left sample, signed.
- APDATA_RIGHT_i  in  I2S_DATA_BITS  right sample, signed.
- APDATA_VALID_i  in  1  one-cycle qualifier for the L/R pair.
- SAMPLE_REQ_o  out  1  one-cycle pulse at each frame load.
- UNDERRUN_o  out  1  one-cycle pulse: frame loaded with no new sample.
- OVERRUN_o  out  1  one-cycle pulse: pending sample overwritten.
- I2S_BCK  out  1  bit clock, AMCLK_i/BCK_DIV, 50% duty.
- I2S_WS  out  1  word select; 0 = left, 1 = right.
- I2S_DATA  out  1  serial data.

Behaviour:
- Reset values:
  - div_ctr = 0; bit_ctr = 2*SLOT_BITS-1.
  - I2S_BCK = 0, I2S_WS = 1, I2S_DATA = 0.
  - Holding, active L/R and last-sample registers = 0; pending = 0.
  - All pulse outputs = 0.
- Reset mid-frame: immediately returns to the reset state; the partial frame is abandoned.
- Divider and BCK:
  - div_ctr runs free, 0..BCK_DIV-1, wrapping.
  - At div_ctr == BCK_DIV/2-1, I2S_BCK <= 1.
  - At div_ctr == BCK_DIV-1, I2S_BCK <= 0. This is the "fall event".
  - First BCK rise occurs at cycle BCK_DIV/2 after reset release; first fall at cycle BCK_DIV.
- On each fall event:
  - bit_ctr <= (bit_ctr+1) mod 2*SLOT_BITS.
  - I2S_WS <= 0 for new bit_ctr in 0..SLOT_BITS-1, else 1.
  - I2S_DATA is updated on the same event. Receivers sample on the BCK rising edge.
- Bit mapping (k = new bit_ctr):
  - k in 1..I2S_DATA_BITS: left bit I2S_DATA_BITS-k.
  - k in SLOT_BITS+1..SLOT_BITS+I2S_DATA_BITS: right bit SLOT_BITS+I2S_DATA_BITS-k.
  - k = 0 when I2S_DATA_BITS == SLOT_BITS: previous frame's right bit 0 (one-BCK I2S delay).
  - All other positions: 0.
- Frame load: occurs at the fall event entering k = 0.
  - If pending: active <= holding, last <= holding, pending <= 0.
  - Else: active <= last (repeat previous sample), UNDERRUN_o pulses.
  - SAMPLE_REQ_o pulses on the same cycle as every load.
  - The k = 0 DATA bit uses the pre-load active right register.
- Input capture, on any cycle with APDATA_VALID_i:
  - holding <= inputs; pending <= 1.
  - If pending was already 1 and this is not a load cycle, OVERRUN_o pulses; the newest sample wins.
- Valid coincident with a load:
  - The load uses the pre-edge holding state.
  - The new sample becomes pending.
  - No overrun, even if pending was already set.
- First frame after reset transmits zeros and pulses UNDERRUN_o.
- Latency: a sample accepted before load event N appears on I2S_DATA starting 1 BCK after load N.

Decomposition:
- Shared package holds:
  - I2S_WS_LEFT = 0, I2S_WS_RIGHT = 1.
  - A FRAME_BITS = 2*SLOT_BITS helper.
  - Default bit widths, so receive and transmit paths stay in lockstep.
- Optional sub-module i2s_bck_gen: divider, BCK output and fall-event strobe. Everything else lives in the top.

Test Plan:
- Reset timing, BCK_DIV=8: release reset_n.
  - BCK rises at cycle 4 and falls at cycle 8.
  - WS goes 1->0 at cycle 8.
  - SAMPLE_REQ_o and UNDERRUN_o pulse at cycle 8.
  - DATA = 0 throughout the first frame.
- Pattern: valid with L = 16'h8001, R = 16'h7FFE before a load.
  - Bench rising-edge sampler decodes MSB first, starting 1 BCK after each WS edge: L = 8001, R = 7FFE.
  - Bits 17..31 of each slot read 0.
- Underrun: supply no further valids after the pattern frame.
  - Next frame repeats 8001/7FFE.
  - UNDERRUN_o pulses exactly once per frame.
- Overrun: two valids (A = 1111/2222, then B = 3333/4444) inside one frame.
  - OVERRUN_o pulses once.
  - Next frame carries B.
- Coincident valid and load: valid C arrives on the load cycle while D is pending.
  - Frame carries D; the following frame carries C.
  - No OVERRUN_o.
- I2S_DATA_BITS = SLOT_BITS = 16:
  - R = 16'h0001 LSB appears at k = 0 of the next frame.
- Reset mid-frame (bit_ctr = 40): asynchronous return to reset values, then a clean restart.
